// File: rtl/clk_nco_bank.sv
// clk_nco_bank: bank of runtime-programmable phase-accumulator NCOs on refclk,
// each producing a clock-enable pulse train, a square wave and a lock flag.
// Revision: 1.0
`default_nettype none

module clk_nco_bank #(
    parameter int                 N_CH        = 4,
    parameter int                 ACC_W       = 32,
    parameter int                 LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0]   DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}},
    parameter int                 CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [ACC_W-1:0]    cfg_inc_i,
    input  logic [ACC_W-1:0]    cfg_phase_i,
    output logic                cfg_err_o,
    output logic [N_CH-1:0]     ce_out_o,
    output logic [N_CH-1:0]     sq_out_o,
    output logic [N_CH-1:0]     ch_locked_o,
    output logic                locked_o
);

    localparam int              CNT_W     = 16;
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES);
    localparam logic [CH_W:0]   N_CH_L    = (CH_W+1)'(N_CH);

    logic [ACC_W-1:0] acc_q [N_CH];
    logic [ACC_W-1:0] acc_d [N_CH];
    logic [ACC_W-1:0] inc_q [N_CH];
    logic [ACC_W-1:0] inc_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    logic [N_CH-1:0]  ce_q, ce_d;
    logic [N_CH-1:0]  sq_q, sq_d;
    logic [N_CH-1:0]  lk_q, lk_d;
    logic [N_CH-1:0]  en;
    logic             locked_q, locked_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             accept;
    logic             ch_ok;
    logic             wr;
    logic [ACC_W:0]   sum;

    always_comb begin
        accept  = cfg_valid_i & ready_q;
        ch_ok   = ({1'b0, cfg_ch_i} < N_CH_L);
        wr      = accept & ch_ok;
        ready_d = ~accept;
        err_d   = accept & ~ch_ok;
    end

    // A write to a channel overrides its carry and its lock-counter expiry on the same edge.
    always_comb begin
        sum = '0;
        en  = '0;
        for (int c = 0; c < N_CH; c++) begin
            en[c]    = |inc_q[c];
            sum      = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            acc_d[c] = acc_q[c];
            inc_d[c] = inc_q[c];
            cnt_d[c] = cnt_q[c];
            ce_d[c]  = 1'b0;
            sq_d[c]  = sq_q[c];
            lk_d[c]  = lk_q[c];
            if (wr && (cfg_ch_i == CH_W'(c))) begin
                inc_d[c] = cfg_inc_i;
                acc_d[c] = cfg_phase_i;
                sq_d[c]  = cfg_phase_i[ACC_W-1];
                lk_d[c]  = 1'b0;
                cnt_d[c] = LOCK_LOAD;
            end else if (!en[c]) begin
                lk_d[c]  = 1'b0;
            end else begin
                acc_d[c] = sum[ACC_W-1:0];
                ce_d[c]  = sum[ACC_W];
                sq_d[c]  = sum[ACC_W-1];
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - 1'b1;
                    if (cnt_q[c] == CNT_W'(1)) begin
                        lk_d[c] = 1'b1;
                    end
                end
            end
        end
        locked_d = (&(lk_q | ~en)) & (|en);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c] <= '0;
                inc_q[c] <= DEFAULT_INC;
                cnt_q[c] <= LOCK_LOAD;
            end
            ce_q     <= '0;
            sq_q     <= '0;
            lk_q     <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c] <= acc_d[c];
                inc_q[c] <= inc_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            ce_q     <= ce_d;
            sq_q     <= sq_d;
            lk_q     <= lk_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;
    assign ce_out_o    = ce_q;
    assign sq_out_o    = sq_q;
    assign ch_locked_o = lk_q;
    assign locked_o    = locked_q;

endmodule

`default_nettype wire
